// File: rtl/cnt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cnt_pkg
// Description : Shared constants and direction encoding for the cnt_if counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_pkg;

   localparam int CNT_WIDTH_DEFAULT = 4;

   typedef enum logic {
      CNT_UP   = 1'b0,
      CNT_DOWN = 1'b1
   } cnt_dir_e;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/cnt_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cnt_if
// Description : Loadable up/down modulo-2^WIDTH counter with all-ones flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_if
   import cnt_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load,
   input  logic             down,
   output logic [WIDTH-1:0] count,
   output logic             rollover
);

   logic [WIDTH-1:0] r_count;
   logic             w_rollover;

   // Load wins over direction; wrap is the natural modulo behaviour of WIDTH bits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (load_en) begin
         r_count <= load;
      end else if (down) begin
         r_count <= r_count - 1'b1;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign w_rollover = &r_count;
   assign count      = r_count;
   assign rollover   = w_rollover;

`ifndef SYNTHESIS
   a_count_known : assert property (@(posedge clk) disable iff (!rstn) !$isunknown(r_count));
   a_rollover    : assert property (@(posedge clk) rollover == (&count));
`endif

endmodule : cnt_if
`default_nettype wire

// File: tb/tb_cnt_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cnt_if
// Description : Self-checking bench for cnt_if: directed cases plus random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_if;
   import cnt_pkg::*;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         rstn;
   logic         load_en;
   logic [W-1:0] load;
   cnt_dir_e     down;
   logic [W-1:0] count;
   logic         rollover;

   int n_cmp;
   int n_err;
   int m_count;

   cnt_if #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .load_en  (load_en),
      .load     (load),
      .down     (down),
      .count    (count),
      .rollover (rollover)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: priority load > down > up, arithmetic modulo 2^W.
   always @(posedge clk or negedge rstn) begin
      if (!rstn)
         m_count = 0;
      else if (load_en)
         m_count = int'(load);
      else if (down == CNT_DOWN)
         m_count = (m_count + MOD - 1) % MOD;
      else
         m_count = (m_count + 1) % MOD;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_count", int'(count), m_count);
      check("model_rollover", int'(rollover), (m_count == MOD - 1) ? 1 : 0);
   end

   task automatic drive(input logic le, input logic [W-1:0] ld, input cnt_dir_e dn);
      load_en = le;
      load    = ld;
      down    = dn;
   endtask

   task automatic expect_next(input string name, input int c, input int r);
      @(negedge clk);
      check({name, "_count"}, int'(count), c);
      check({name, "_roll"}, int'(rollover), r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rstn  = 1'b0;
      drive(1'b0, 4'h0, CNT_UP);

      repeat (5) expect_next("reset", 0, 0);
      #1 rstn = 1'b1;
      expect_next("first_edge", 1, 0);

      drive(1'b1, 4'hE, CNT_UP);
      expect_next("up_load", 14, 0);
      drive(1'b0, 4'h0, CNT_UP);
      expect_next("up_f", 15, 1);
      expect_next("up_wrap", 0, 0);
      expect_next("up_1", 1, 0);

      drive(1'b1, 4'h1, CNT_UP);
      expect_next("dn_load", 1, 0);
      drive(1'b0, 4'h0, CNT_DOWN);
      expect_next("dn_0", 0, 0);
      expect_next("dn_wrap", 15, 1);
      expect_next("dn_e", 14, 0);

      drive(1'b1, 4'h7, CNT_UP);
      expect_next("pri_load7", 7, 0);
      drive(1'b1, 4'h3, CNT_DOWN);
      expect_next("pri_load3", 3, 0);
      drive(1'b1, 4'hF, CNT_DOWN);
      repeat (3) expect_next("pri_hold_f", 15, 1);

      drive(1'b1, 4'h5, CNT_UP);
      expect_next("dir_load5", 5, 0);
      drive(1'b0, 4'h0, CNT_UP);
      expect_next("dir_up6", 6, 0);
      drive(1'b0, 4'h0, CNT_DOWN);
      expect_next("dir_dn5", 5, 0);

      drive(1'b1, 4'h8, CNT_UP);
      expect_next("async_load8", 8, 0);
      drive(1'b0, 4'h0, CNT_UP);
      expect_next("async_9", 9, 0);
      #2 rstn = 1'b0;
      #1;
      check("async_immediate", int'(count), 0);
      check("async_immediate_roll", int'(rollover), 0);
      expect_next("async_held", 0, 0);
      #1 rstn = 1'b1;
      expect_next("async_resume", 1, 0);

      for (int i = 0; i < 200; i++) begin
         #($urandom_range(1, 30));
         if (($time % 10) == 5) #1;
         load    = W'($urandom_range(0, MOD - 1));
         load_en = ($urandom_range(0, 3) == 0);
         down    = cnt_dir_e'($urandom_range(0, 1));
      end
      drive(1'b0, 4'h0, CNT_UP);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_cnt_if
`default_nettype wire
